// File: rtl/khu_uart_pkg.sv
// Shared types and constants for the PC-bound UART framing path.
// Other files in this slice pull these in with a wildcard import.
package khu_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SOF     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } tx_state_e;

    localparam logic [7:0] SOF_BYTE_DEFAULT      = 8'h7E;
    localparam int         PAYLOAD_BYTES_DEFAULT = 5;

    // Total bytes on the wire per frame: SOF + payload + checksum.
    localparam int         FRAME_LEN             = PAYLOAD_BYTES_DEFAULT + 2;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Word-in / byte-out valid-ready bundle between sensor_core, the framer and uart_controller.
// The framer uses the slave view; the environment that feeds words and drains bytes uses master.
interface uart_tx_framer_if #(
    parameter int WORD_W = 40
);

    logic [WORD_W-1:0] i_DATA;
    logic              i_DATA_VALID;
    logic              o_DATA_READY;
    logic [7:0]        o_BYTE;
    logic              o_BYTE_VALID;
    logic              i_BYTE_READY;

    modport slave (
        input  i_DATA,
        input  i_DATA_VALID,
        output o_DATA_READY,
        output o_BYTE,
        output o_BYTE_VALID,
        input  i_BYTE_READY
    );

    modport master (
        output i_DATA,
        output i_DATA_VALID,
        input  o_DATA_READY,
        input  o_BYTE,
        input  o_BYTE_VALID,
        output i_BYTE_READY
    );

endinterface

// File: rtl/uart_tx_framer.sv
// Serialises one sensor word into SOF, MSB-first payload bytes and an XOR checksum.
// The word is captured locally so the core is released after a single handshake.
module uart_tx_framer
    import khu_uart_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = PAYLOAD_BYTES_DEFAULT,
    parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEFAULT
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTN,
    uart_tx_framer_if.slave       bus,
    output logic                  o_BUSY,
    output logic [15:0]           o_FRAME_CNT
);

    localparam int              WORD_W   = 8 * PAYLOAD_BYTES;
    localparam int              IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    tx_state_e          state_q, state_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [7:0]         csum_q, csum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               word_acc;
    logic               byte_acc;

    // Handshakes decoded straight from the state register so no input feeds an output.
    assign word_acc = (state_q == ST_IDLE) && bus.i_DATA_VALID;
    assign byte_acc = (state_q != ST_IDLE) && bus.i_BYTE_READY;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            csum_q      <= 8'h00;
            idx_q       <= '0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (word_acc) begin
                    shift_d = bus.i_DATA;
                    csum_d  = 8'h00;
                    idx_d   = '0;
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                if (byte_acc) begin
                    idx_d   = '0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // The outgoing byte always sits in the top lane; shifting exposes the next one.
                if (byte_acc) begin
                    csum_d  = csum_q ^ shift_q[WORD_W-1 -: 8];
                    shift_d = shift_q << 8;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (byte_acc) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.o_BYTE       = 8'h00;
        bus.o_BYTE_VALID = 1'b0;
        bus.o_DATA_READY = 1'b0;
        o_BUSY           = 1'b1;

        case (state_q)
            ST_IDLE: begin
                bus.o_DATA_READY = 1'b1;
                o_BUSY           = 1'b0;
            end
            ST_SOF: begin
                bus.o_BYTE       = SOF_BYTE;
                bus.o_BYTE_VALID = 1'b1;
            end
            ST_PAYLOAD: begin
                bus.o_BYTE       = shift_q[WORD_W-1 -: 8];
                bus.o_BYTE_VALID = 1'b1;
            end
            ST_CSUM: begin
                bus.o_BYTE       = csum_q;
                bus.o_BYTE_VALID = 1'b1;
            end
            default: begin
                o_BUSY = 1'b0;
            end
        endcase
    end

    assign o_FRAME_CNT = frame_cnt_q;

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Framing stage between `sensor_core` and `uart_controller` on the PC-bound path. It accepts one 40-bit sensor word per valid/ready handshake and serialises it into a 7-byte frame on a byte-wide valid/ready stream: start-of-frame byte, 5 payload bytes MSB first, then an XOR checksum. It holds the word locally so the core is released after one cycle, and it tolerates arbitrary backpressure from the byte consumer.

## Interface
Parameters:
- `PAYLOAD_BYTES`, 5: payload bytes per frame; word width is 8*`PAYLOAD_BYTES`.
- `SOF_BYTE`, 8'h7E: start-of-frame marker.

Ports:
- `i_CLK`  in  1  system clock; single clock domain.
- `i_RSTN`  in  1  asynchronous, active-low reset.
- `i_DATA`  in  40  word to send; sampled on accept.
- `i_DATA_VALID`  in  1  upstream word valid.
- `o_DATA_READY`  out  1  framer can accept a word.
- `o_BYTE`  out  8  current frame byte.
- `o_BYTE_VALID`  out  1  `o_BYTE` valid.
- `i_BYTE_READY`  in  1  downstream takes byte this cycle.
- `o_BUSY`  out  1  frame in progress.
- `o_FRAME_CNT`  out  16  completed frames, wrapping.

## Operation
- The word accept event is `i_DATA_VALID & o_DATA_READY`. The byte accept event is `o_BYTE_VALID & i_BYTE_READY`.
- States: IDLE, SOF, PAYLOAD, CSUM.
  - IDLE: `o_DATA_READY`=1. On word accept: latch `i_DATA` into a shift register, clear the checksum, go to SOF.
  - SOF: `o_BYTE`=`SOF_BYTE`. On byte accept, go to PAYLOAD with byte index 0.
  - PAYLOAD: `o_BYTE` = shift register [39:32]. On byte accept:
    - XOR that byte into the checksum.
    - Shift left by 8.
    - Increment the index. After index `PAYLOAD_BYTES`-1, go to CSUM.
  - CSUM: `o_BYTE` = checksum, which is the XOR of the 5 payload bytes. On byte accept:
    - Increment `o_FRAME_CNT` (0xFFFF wraps to 0x0000).
    - Return to IDLE.
- `o_BYTE_VALID`=1 in SOF, PAYLOAD and CSUM; 0 in IDLE. `o_BUSY` = not IDLE.
- `o_DATA_READY` = (state==IDLE), decoded combinationally from the state register.
- `i_DATA_VALID` while busy is ignored. The word stays pending upstream and is accepted in the next IDLE cycle.
- Payload bytes equal to `SOF_BYTE` are sent raw, with no escaping.
- `o_BYTE` must stay stable while `o_BYTE_VALID`=1 and `i_BYTE_READY`=0.
- Reset (async assert, at any time including mid-frame):
  - state IDLE, `o_BYTE`=0x00, `o_BYTE_VALID`=0, `o_BUSY`=0, `o_DATA_READY`=1, `o_FRAME_CNT`=0, shift register and checksum cleared.
  - The partial frame is discarded and never resumed.

## Timing
- Word accepted at edge N: at N+1 `o_BYTE_VALID`=1 and `o_BYTE`=0x7E.
- All byte outputs are registered. The next byte appears in the cycle after the byte accept, so `i_BYTE_READY` held at 1 gives one byte per cycle.
- Minimum frame: 7 byte cycles. `o_DATA_READY` returns the cycle after the CSUM accept, so back-to-back throughput is one frame per 8 cycles.
- `o_FRAME_CNT` updates on the same edge as the CSUM accept.
- Backpressure: each stalled cycle extends the frame by exactly one cycle. No byte is lost or duplicated.

## Structure
- Shared package `khu_uart_pkg` holds:
  - the state enum (IDLE, SOF, PAYLOAD, CSUM)
  - `SOF_BYTE_DEFAULT` = 8'h7E
  - `FRAME_LEN` = `PAYLOAD_BYTES`+2
- Single flat module. No sub-module is warranted; the shift register, checksum, index counter and FSM fit in one always block plus output decode.

## Test plan
- `i_DATA`=40'h0102030405 with `i_BYTE_READY`=1 -> bytes 7E 01 02 03 04 05 01 on 7 consecutive cycles starting N+1; `o_FRAME_CNT`=1; `o_DATA_READY` high again at N+8.
- Same word with `i_BYTE_READY` toggling 1,0,0,1,... -> identical byte sequence; `o_BYTE` stable during every stall; frame length = 7 + stall cycles.
- `i_DATA_VALID` held with 40'hAAAAAAAAAA then 40'h7E00000000 -> second word accepted only after the first CSUM; second frame is 7E 7E 00 00 00 00 7E, with the payload 0x7E sent raw.
- `i_RSTN` pulsed low during the third payload byte -> all outputs reach reset values asynchronously; the next word produces a clean full frame; `o_FRAME_CNT` restarts from 1.
- Preload via 65535 frames (or force the counter to 0xFFFF), then one more frame -> `o_FRAME_CNT`=0x0000.
- 40'hFFFFFFFFFF -> checksum 0xFF; 40'h0000000000 -> checksum 0x00.
